// File: rtl/sdp_ram_read_port_pkg.sv
// Shared helpers for the simple-dual-port RAM read front-end: address sizing,
// credit count and the overflow-check macro.
`ifndef SDP_RAM_READ_PORT_PKG_SV
`define SDP_RAM_READ_PORT_PKG_SV

package sdp_ram_pkg;

    localparam int OUT_W = 3;

    // Same sizing function as the RAM, so both sides agree on the address width.
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        while (d > 0) begin
            r = r + 1;
            d = d >> 1;
        end
        return r;
    endfunction

    // Every in-flight read must have a guaranteed FIFO slot; two extra entries cover
    // the registered credit decision and give full throughput.
    function automatic int credits(input int latency);
        return latency + 2;
    endfunction

endpackage

`ifndef SDP_ASSERT_NEVER
`define SDP_ASSERT_NEVER(clk, rst, cond) assert property (@(posedge clk) disable iff (rst) !(cond))
`endif

`endif

// File: rtl/sdp_ram_read_port_if.sv
// Request, response and RAM read-port signals of the read front-end.
// slave is the front-end's view; master is the controller/RAM side seen from outside.
interface sdp_ram_read_port_if
    import sdp_ram_pkg::*;
#(
    parameter int RAM_WIDTH = 64,
    parameter int AW        = 9
);
    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    logic [AW-1:0]        req_addr;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RAM_WIDTH-1:0] resp_data;
    logic [AW-1:0]        ram_addrb;
    logic                 ram_enb;
    logic                 ram_regceb;
    logic                 ram_rstb;
    logic [RAM_WIDTH-1:0] ram_doutb;
    logic [OUT_W-1:0]     outstanding;

    modport slave (
        input  flush, req_valid, req_addr, resp_ready, ram_doutb,
        output req_ready, resp_valid, resp_data, ram_addrb, ram_enb,
               ram_regceb, ram_rstb, outstanding
    );

    modport master (
        output flush, req_valid, req_addr, resp_ready, ram_doutb,
        input  req_ready, resp_valid, resp_data, ram_addrb, ram_enb,
               ram_regceb, ram_rstb, outstanding
    );
endinterface

// File: rtl/sdp_ram_read_port_resp_fifo.sv
// Circular response buffer, occupancy-counted; head visible the cycle after push.
// Flush drops the same-edge push/pop; pop on empty is ignored, push on full is the caller's bug.
module sdp_rd_resp_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_push   = push & ~flush;
    assign do_pop    = pop & (count != '0) & ~flush;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/sdp_ram_read_port.sv
// Read front-end for the SDP block RAM: accepts reads, tracks the RAM pipeline, returns data in order.
// Latency READ_LATENCY+1 to resp_valid; credit-based req_ready never depends on resp_ready.
module sdp_ram_read_port
    import sdp_ram_pkg::*;
#(
    parameter int RAM_WIDTH    = 64,
    parameter int RAM_DEPTH    = 512,
    parameter int READ_LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    sdp_ram_read_port_if.slave  bus
);
    localparam int AW      = clogb2(RAM_DEPTH - 1);
    localparam int CREDITS = credits(READ_LATENCY);
    localparam int OCC_W   = $clog2(CREDITS + 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sdp_ram_read_port: READ_LATENCY must be 1 or 2");
    end

    logic [READ_LATENCY-1:0] pend;
    logic [OCC_W-1:0]        occ;
    logic [OUT_W-1:0]        pend_cnt;
    logic [OUT_W-1:0]        outstanding;
    logic                    accept;
    logic                    pop;
    logic                    push;
    logic [AW-1:0]           addr_unused_chk;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pend_cnt = pend_cnt + OUT_W'(pend[i]);
        end
    end

    // Credits count everything that will eventually need a FIFO slot.
    assign outstanding   = pend_cnt + OUT_W'(occ);
    assign bus.req_ready = (outstanding < OUT_W'(CREDITS)) & ~bus.flush & ~reset;
    assign accept        = bus.req_valid & bus.req_ready;
    assign push          = pend[READ_LATENCY-1];
    assign pop           = bus.resp_valid & bus.resp_ready;

    assign addr_unused_chk = bus.req_addr;
    assign bus.ram_addrb   = addr_unused_chk;
    assign bus.ram_enb     = accept;
    assign bus.ram_regceb  = 1'b1;
    assign bus.ram_rstb    = reset;
    assign bus.outstanding = outstanding;
    assign bus.resp_valid  = (occ != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else if (bus.flush) begin
            pend <= '0;
        end else begin
            pend[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pend[i] <= pend[i-1];
            end
        end
    end

    sdp_rd_resp_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (CREDITS)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.flush),
        .push      (push),
        .push_data (bus.ram_doutb),
        .pop       (pop),
        .count     (occ),
        .head_data (bus.resp_data)
    );

    a_no_overflow: `SDP_ASSERT_NEVER(clock, reset,
        push && !pop && !bus.flush && (occ == OCC_W'(CREDITS)));
endmodule

// File: tb/tb_sdp_ram_read_port.sv
// Directed bench for both latency builds of sdp_ram_read_port against a behavioural SDP RAM.
module tb_sdp_ram_read_port;
    logic clock;
    logic reset;

    sdp_ram_read_port_if #(.RAM_WIDTH(64), .AW(9)) b2 ();
    sdp_ram_read_port_if #(.RAM_WIDTH(64), .AW(9)) b1 ();

    sdp_ram_read_port #(.RAM_WIDTH(64), .RAM_DEPTH(512), .READ_LATENCY(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    sdp_ram_read_port #(.RAM_WIDTH(64), .RAM_DEPTH(512), .READ_LATENCY(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    logic [63:0] mem [512];
    logic [63:0] st2;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'(i) * 3;
    end

    // Output-register RAM build: address latched on the accept edge, data one edge later.
    always_ff @(posedge clock) begin
        if (b2.ram_enb) st2 <= mem[b2.ram_addrb];
        if (b2.ram_rstb) b2.ram_doutb <= '0;
        else if (b2.ram_regceb) b2.ram_doutb <= st2;
    end

    always_ff @(posedge clock) begin
        if (b1.ram_rstb) b1.ram_doutb <= '0;
        else if (b1.ram_enb) b1.ram_doutb <= mem[b1.ram_addrb];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          n_checks;
    int          n_fail;
    int          cyc_n;
    int          n_pop;
    logic [63:0] sb[$];
    logic        s_rdy, s_rv, s_acc, s_pop, s_enb;
    logic [63:0] s_data;
    logic [2:0]  s_out;
    logic [2:0]  max_out;
    logic [8:0]  s_addrb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One cycle: drive at negedge, sample, then score the coming posedge.
    task automatic cyc(input bit sel, input bit v, input logic [8:0] a, input bit rr, input bit fl);
        @(negedge clock);
        if (sel == 1'b0) begin
            b2.req_valid = v; b2.req_addr = a; b2.resp_ready = rr; b2.flush = fl;
            b1.req_valid = 1'b0; b1.resp_ready = 1'b0; b1.flush = 1'b0;
        end else begin
            b1.req_valid = v; b1.req_addr = a; b1.resp_ready = rr; b1.flush = fl;
            b2.req_valid = 1'b0; b2.resp_ready = 1'b0; b2.flush = 1'b0;
        end
        #1;
        s_rdy   = sel ? b1.req_ready   : b2.req_ready;
        s_rv    = sel ? b1.resp_valid  : b2.resp_valid;
        s_data  = sel ? b1.resp_data   : b2.resp_data;
        s_out   = sel ? b1.outstanding : b2.outstanding;
        s_enb   = sel ? b1.ram_enb     : b2.ram_enb;
        s_addrb = sel ? b1.ram_addrb   : b2.ram_addrb;
        s_acc   = v & s_rdy;
        s_pop   = s_rv & rr & ~fl;
        if (s_pop) begin
            n_pop++;
            if (sb.size() == 0) check("resp_unexpected", 64'(s_rv), 64'd0);
            else check("resp_data", s_data, sb.pop_front());
        end
        if (s_acc) sb.push_back(64'(a) * 3);
        if (fl) sb.delete();
        if (s_out > max_out) max_out = s_out;
        cyc_n++;
    endtask

    task automatic drain(input bit sel, input int bound);
        for (int k = 0; k < bound && sb.size() != 0; k++) cyc(sel, 1'b0, 9'd0, 1'b1, 1'b0);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc, first_pop, last_pop, last_acc, npop, nacc, acc_after, p;
        n_checks = 0; n_fail = 0; cyc_n = 0; n_pop = 0; max_out = '0;
        reset = 1'b1;
        b2.req_valid = 0; b2.req_addr = '0; b2.resp_ready = 0; b2.flush = 0;
        b1.req_valid = 0; b1.req_addr = '0; b1.resp_ready = 0; b1.flush = 0;

        @(negedge clock); #1;
        check("rst_req_ready", 64'(b2.req_ready), 64'd0);
        check("rst_resp_valid", 64'(b2.resp_valid), 64'd0);
        check("rst_outstanding", 64'(b2.outstanding), 64'd0);
        check("rst_ram_rstb", 64'(b2.ram_rstb), 64'd1);
        check("rst_l1_resp_valid", 64'(b1.resp_valid), 64'd0);
        check("ram_regceb", 64'(b2.ram_regceb), 64'd1);
        reset = 1'b0;

        // Back-to-back reads 0..15.
        first_acc = -1; first_pop = -1; last_pop = 0; last_acc = 0; npop = 0; nacc = 0;
        for (int k = 0; k < 60 && npop < 16; k++) begin
            cyc(1'b0, nacc < 16, 9'(nacc), 1'b1, 1'b0);
            if (k == 0) check("post_rst_req_ready", 64'(s_rdy), 64'd1);
            if (s_acc) begin
                if (first_acc < 0) first_acc = cyc_n;
                last_acc = cyc_n;
                nacc++;
            end
            if (s_pop) begin
                if (first_pop < 0) first_pop = cyc_n;
                last_pop = cyc_n;
                npop++;
            end
            if (k == 5) check("steady_outstanding", 64'(s_out), 64'd3);
        end
        check("b2b_count", 64'(npop), 64'd16);
        check("b2b_latency", 64'(first_pop - first_acc), 64'd3);
        check("b2b_no_bubble", 64'(last_pop - first_pop), 64'd15);
        check("b2b_accept_rate", 64'(last_acc - first_acc), 64'd15);
        drain(1'b0, 20);

        // Backpressure: resp_ready low for 10 cycles.
        nacc = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 9'(100 + nacc), 1'b0, 1'b0);
            if (s_acc) nacc++;
        end
        check("bp_accepts", 64'(nacc), 64'd4);
        check("bp_req_ready", 64'(s_rdy), 64'd0);
        check("bp_outstanding", 64'(s_out), 64'd4);
        first_pop = -1; acc_after = -1;
        for (int k = 0; k < 30 && (first_pop < 0 || acc_after < 0); k++) begin
            cyc(1'b0, 1'b1, 9'(100 + nacc), 1'b1, 1'b0);
            if (s_pop && first_pop < 0) first_pop = cyc_n;
            if (s_acc) begin
                if (acc_after < 0) acc_after = cyc_n;
                nacc++;
            end
        end
        check("bp_resume", 64'(acc_after - first_pop), 64'd1);
        drain(1'b0, 30);

        // Random valid/ready, 2000 requests.
        nacc = 0; max_out = '0; n_pop = 0;
        for (int k = 0; k < 20000 && nacc < 2000; k++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                1'($urandom_range(0, 1)), 1'b0);
            if (s_acc) nacc++;
        end
        check("rand_accepts", 64'(nacc), 64'd2000);
        drain(1'b0, 40);
        check("rand_pops", 64'(n_pop), 64'd2000);
        check("rand_max_out_le_credits", 64'(max_out <= 3'd4), 64'd1);

        // Flush with two reads in the pipeline and two buffered.
        nacc = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 9'(200 + k), 1'b0, 1'b0);
            if (s_acc) nacc++;
        end
        check("flush_setup_accepts", 64'(nacc), 64'd4);
        cyc(1'b0, 1'b1, 9'd204, 1'b1, 1'b1);
        check("flush_pre_outstanding", 64'(s_out), 64'd4);
        check("flush_req_ready", 64'(s_rdy), 64'd0);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
        check("flush_resp_valid", 64'(s_rv), 64'd0);
        check("flush_outstanding", 64'(s_out), 64'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 9'd0, 1'b1, 1'b0);
        check("flush_no_stale", 64'(s_rv), 64'd0);
        n_pop = 0;
        cyc(1'b0, 1'b1, 9'd9, 1'b1, 1'b0);
        drain(1'b0, 20);
        check("flush_after_pops", 64'(n_pop), 64'd1);

        // Asynchronous reset between edges, mid-stream.
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 9'(300 + k), 1'b0, 1'b0);
        @(negedge clock); #3;
        reset = 1'b1;
        #1;
        check("arst_resp_valid", 64'(b2.resp_valid), 64'd0);
        check("arst_outstanding", 64'(b2.outstanding), 64'd0);
        check("arst_req_ready", 64'(b2.req_ready), 64'd0);
        check("arst_ram_rstb", 64'(b2.ram_rstb), 64'd1);
        sb.delete();
        b2.req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        cyc(1'b0, 1'b1, 9'd7, 1'b1, 1'b0);
        check("arst_release_ready", 64'(s_rdy), 64'd1);
        check("ram_addrb", 64'(s_addrb), 64'd7);
        check("ram_enb", 64'(s_enb), 64'd1);
        n_pop = 0;
        drain(1'b0, 20);
        check("arst_read7_pops", 64'(n_pop), 64'd1);

        // READ_LATENCY = 1 build.
        cyc(1'b1, 1'b1, 9'd5, 1'b1, 1'b0);
        check("l1_accept", 64'(s_acc), 64'd1);
        first_acc = cyc_n; p = -1;
        for (int k = 0; k < 10 && p < 0; k++) begin
            cyc(1'b1, 1'b0, 9'd0, 1'b1, 1'b0);
            if (s_pop) p = cyc_n;
        end
        check("l1_latency", 64'(p - first_acc), 64'd2);
        nacc = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 9'(400 + nacc), 1'b0, 1'b0);
            if (s_acc) nacc++;
        end
        check("l1_bp_accepts", 64'(nacc), 64'd3);
        check("l1_bp_req_ready", 64'(s_rdy), 64'd0);
        check("l1_bp_outstanding", 64'(s_out), 64'd3);
        drain(1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
